ring_buffer_reader: RTL and testbench

Read-side master for the RingBuffer FIFO. Whenever the buffer reports stored data, the block issues single-cycle read requests and waits for the buffer's acknowledge. It captures each returned byte into an output register and presents it downstream on a valid/ready handshake. It sits between RingBuffer and any byte consumer (serializer, bus bridge), so consumers never drive `readEnable` directly.

---
 rtl/ring_pkg.sv | 24 ++
 rtl/ring_buffer_reader_if.sv | 34 +++
 rtl/ring_out_reg.sv | 38 +++
 rtl/ring_buffer_reader.sv | 109 ++++++++++
 tb/tb_ring_buffer_reader.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ring_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ring_pkg                                                             |
// | Shared widths and read-FSM state encoding for the RingBuffer blocks. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ring_pkg;

  localparam int RING_DATA_W = 8;
  localparam int RING_LEN_W  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    GAP  = 2'd3
  } ring_rd_state_t;

  function automatic int ring_cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ring_buffer_reader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ring_buffer_reader_if                                                |
// | Read-side bus between RingBuffer (slave) and its reader (master).    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface ring_buffer_reader_if
  import ring_pkg::*;
#(
  parameter int DATA_WIDTH   = RING_DATA_W,
  parameter int LENGTH_WIDTH = RING_LEN_W
);

  logic                    readEnable;
  logic                    dataReadAck;
  logic [DATA_WIDTH-1:0]   dataRead;
  logic [LENGTH_WIDTH-1:0] bufferLength;

  modport master (
    output readEnable,
    input  dataReadAck,
    input  dataRead,
    input  bufferLength
  );

  modport slave (
    input  readEnable,
    output dataReadAck,
    output dataRead,
    output bufferLength
  );

endinterface
`default_nettype wire

// File: rtl/ring_out_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ring_out_reg                                                         |
// | One-entry valid/ready output register; a capture beats a drain.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ring_out_reg #(
  parameter int WIDTH = 8
) (
  input  wire              clk,
  input  wire              reset,
  input  wire              i_capture,
  input  wire [WIDTH-1:0]  i_capture_data,
  input  wire              i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_capture) begin
      r_valid <= 1'b1;
      r_data  <= i_capture_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/ring_buffer_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ring_buffer_reader                                                   |
// | Issues RingBuffer reads and presents each byte on valid/ready.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ring_buffer_reader
  import ring_pkg::*;
#(
  parameter int DATA_WIDTH   = RING_DATA_W,
  parameter int LENGTH_WIDTH = RING_LEN_W,
  parameter int TIMEOUT      = 15
) (
  input  wire                     clk,
  input  wire                     reset,
  input  wire                     drainEnable,
  ring_buffer_reader_if.master    rb,
  output logic                    outValid,
  input  wire                     outReady,
  output logic [DATA_WIDTH-1:0]   outData,
  output logic [LENGTH_WIDTH-1:0] bytesRead,
  output logic                    readTimeout
);

  localparam int                 c_CNT_W     = ring_cnt_width(TIMEOUT);
  localparam logic [c_CNT_W-1:0] c_WAIT_LAST = c_CNT_W'(TIMEOUT - 1);

  ring_rd_state_t     r_state;
  ring_rd_state_t     w_next_state;
  logic [c_CNT_W-1:0] r_wait_cnt;
  logic               r_read_enable;
  logic               w_slot_free;
  logic               w_capture;
  logic               w_expire;

  // Slot is free when empty or being drained this very cycle.
  assign w_slot_free = !outValid || outReady;

  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_expire     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (drainEnable && (rb.bufferLength != '0) && w_slot_free) begin
          w_next_state = REQ;
        end
      end
      REQ: begin
        w_next_state = WAIT;
      end
      WAIT: begin
        if (rb.dataReadAck) begin
          w_capture    = 1'b1;
          w_next_state = GAP;
        end else if (r_wait_cnt == c_WAIT_LAST) begin
          w_expire     = 1'b1;
          w_next_state = GAP;
        end
      end
      GAP: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_wait_cnt    <= '0;
      r_read_enable <= 1'b0;
      bytesRead     <= '0;
      readTimeout   <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_read_enable <= (w_next_state == REQ);
      if (r_state == REQ) begin
        r_wait_cnt <= '0;
      end else if (r_state == WAIT) begin
        r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
      end
      if (w_capture) begin
        bytesRead <= bytesRead + LENGTH_WIDTH'(1);
      end
      if (w_expire) begin
        readTimeout <= 1'b1;
      end
    end
  end

  assign rb.readEnable = r_read_enable;

  ring_out_reg #(
    .WIDTH (DATA_WIDTH)
  ) u_out_reg (
    .clk            (clk),
    .reset          (reset),
    .i_capture      (w_capture),
    .i_capture_data (rb.dataRead),
    .i_ready        (outReady),
    .o_valid        (outValid),
    .o_data         (outData)
  );

endmodule
`default_nettype wire

// File: tb/tb_ring_buffer_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ring_buffer_reader                                                |
// | Self-checking bench with a RingBuffer responder and byte scoreboard. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ring_buffer_reader;
  import ring_pkg::*;

  localparam int DW    = 8;
  localparam int LW    = 32;
  localparam int TO    = 15;
  localparam int NEVER = 255;

  typedef struct {
    int          n;
    logic [31:0] data;
    int          delay;
    int          exp_pulses;
    int          exp_gap;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          drainEnable = 1'b0;
  logic          outReady = 1'b0;
  logic          outValid;
  logic [DW-1:0] outData;
  logic [LW-1:0] bytesRead;
  logic          readTimeout;

  ring_buffer_reader_if #(.DATA_WIDTH(DW), .LENGTH_WIDTH(LW)) rb ();

  ring_buffer_reader #(.DATA_WIDTH(DW), .LENGTH_WIDTH(LW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .drainEnable(drainEnable), .rb(rb),
    .outValid(outValid), .outReady(outReady), .outData(outData),
    .bytesRead(bytesRead), .readTimeout(readTimeout)
  );

  // Standalone output register for the capture-during-drain corner.
  logic          or_cap = 1'b0, or_ready = 1'b0, or_valid;
  logic [DW-1:0] or_data = '0, or_out;
  ring_out_reg #(.WIDTH(DW)) u_oreg (
    .clk(clk), .reset(reset), .i_capture(or_cap), .i_capture_data(or_data),
    .i_ready(or_ready), .o_valid(or_valid), .o_data(or_out)
  );

  always #5 clk = ~clk;

  // RingBuffer model: main owns wr_ptr, responder owns rd_ptr.
  logic [7:0] mem [0:255];
  int         wr_ptr = 0, rd_ptr = 0, ack_delay = 1, resp_cnt = 0;
  logic       resp_ack = 1'b0, spur_ack = 1'b0;
  logic [7:0] resp_data = '0, spur_data = '0;

  assign rb.dataReadAck  = resp_ack | spur_ack;
  assign rb.dataRead     = spur_ack ? spur_data : resp_data;
  assign rb.bufferLength = LW'(wr_ptr - rd_ptr);

  initial forever begin
    @(negedge clk);
    resp_ack = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        resp_ack  = 1'b1;
        resp_data = mem[rd_ptr % 256];
        rd_ptr++;
      end
    end
    if (rb.readEnable && ack_delay != NEVER) resp_cnt = ack_delay;
  end

  // Monitor: records pulses, accepted bytes and the timeout rise.
  int         cyc = 0, to_rise = -1;
  int         pulse_q[$];
  logic [7:0] got_q[$];
  bit         prev_re = 1'b0, wide_re = 1'b0, prev_to = 1'b0;

  initial forever begin
    @(negedge clk);
    #2;
    cyc++;
    if (rb.readEnable) begin
      if (prev_re) wide_re = 1'b1;
      else pulse_q.push_back(cyc);
    end
    prev_re = rb.readEnable;
    if (outValid && outReady) got_q.push_back(outData);
    if (readTimeout && !prev_to) to_rise = cyc;
    prev_to = readTimeout;
  end

  int         vectors = 0, miscompares = 0, exp_bytes = 0, got_rd = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic preload(input logic [7:0] b, input bit expect_out);
    mem[wr_ptr % 256] = b;
    wr_ptr++;
    if (expect_out) begin
      exp_q.push_back(b);
      exp_bytes++;
    end
  endtask

  task automatic sb_check();
    while (got_rd < got_q.size()) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_unexpected: got 0x%0h, expected no byte", got_q[got_rd]);
      end else begin
        chk("sb_byte", 32'(got_q[got_rd]), 32'(exp_q.pop_front()));
      end
      got_rd++;
    end
  endtask

  task automatic wait_got(input int target, input int budget);
    int n = 0;
    while (got_q.size() < target && n < budget) begin
      tick();
      n++;
    end
    chk("drain_done", 32'(got_q.size()), 32'(target));
  endtask

  task automatic wait_pulses(input int target, input int budget);
    int n = 0;
    while (pulse_q.size() < target && n < budget) begin
      tick();
      n++;
    end
    chk("pulse_seen", 32'(pulse_q.size()), 32'(target));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int   p0, g0, p, n, accepts;
    bit   stable;
    vecs[0] = '{3, 32'h0003_0201, 1, 3, 4};
    vecs[1] = '{2, 32'h0000_5AA5, 3, 2, 6};
    vecs[2] = '{1, 32'h0000_00C3, TO, 1, TO + 3};
    vecs[3] = '{4, 32'h4030_2010, 7, 4, 10};

    // Reset state
    repeat (3) tick();
    chk("rst_outValid", 32'(outValid), 0);
    chk("rst_outData", 32'(outData), 0);
    chk("rst_bytesRead", bytesRead, 0);
    chk("rst_readTimeout", 32'(readTimeout), 0);
    chk("rst_readEnable", 32'(rb.readEnable), 0);
    reset = 1'b1;
    drainEnable = 1'b1;
    outReady = 1'b1;
    repeat (2) tick();

    // Table-driven drains with various ack latencies
    for (int v = 0; v < 4; v++) begin
      p0 = pulse_q.size();
      g0 = got_q.size();
      ack_delay = vecs[v].delay;
      for (int i = 0; i < vecs[v].n; i++) preload(vecs[v].data[8*i +: 8], 1'b1);
      wait_got(g0 + vecs[v].n, 40 * vecs[v].n + 40);
      repeat (6) tick();
      sb_check();
      chk("vec_pulses", 32'(pulse_q.size() - p0), 32'(vecs[v].exp_pulses));
      for (int k = 0; k + 1 < vecs[v].n && p0 + k + 1 < pulse_q.size(); k++)
        chk("vec_pulse_gap", 32'(pulse_q[p0+k+1] - pulse_q[p0+k]), 32'(vecs[v].exp_gap));
      chk("vec_bytesRead", bytesRead, 32'(exp_bytes));
      chk("vec_readTimeout", 32'(readTimeout), 0);
    end

    // Backpressure: first byte held 20 cycles, one request only
    outReady = 1'b0;
    ack_delay = 1;
    p0 = pulse_q.size();
    g0 = got_q.size();
    preload(8'h05, 1'b1);
    preload(8'h06, 1'b1);
    n = 0;
    while (!outValid && n < 20) begin tick(); n++; end
    chk("bp_valid", 32'(outValid), 1);
    stable = 1'b1;
    repeat (20) begin
      tick();
      if (outData !== 8'h05 || outValid !== 1'b1) stable = 1'b0;
    end
    chk("bp_hold_stable", 32'(stable), 1);
    chk("bp_stall_pulses", 32'(pulse_q.size() - p0), 1);
    outReady = 1'b1;
    wait_got(g0 + 2, 60);
    sb_check();

    // Empty buffer: no requests
    p0 = pulse_q.size();
    repeat (50) tick();
    chk("empty_pulses", 32'(pulse_q.size() - p0), 0);

    // drainEnable dropped during WAIT, ack 3 cycles later
    ack_delay = 4;
    p0 = pulse_q.size();
    g0 = got_q.size();
    preload(8'h11, 1'b1);
    preload(8'h22, 1'b0);
    wait_pulses(p0 + 1, 10);
    drainEnable = 1'b0;
    wait_got(g0 + 1, 30);
    repeat (10) tick();
    sb_check();
    chk("dis_pulses", 32'(pulse_q.size() - p0), 1);
    chk("dis_bytesRead", bytesRead, 32'(exp_bytes));
    exp_q.push_back(8'h22);
    exp_bytes++;
    drainEnable = 1'b1;
    wait_got(g0 + 2, 30);
    sb_check();

    // Capture in the same cycle the held byte is accepted
    accepts = 0;
    or_cap = 1'b1; or_data = 8'h07; or_ready = 1'b0;
    tick();
    or_cap = 1'b0;
    tick();
    chk("sim_hold_data", 32'(or_out), 32'h07);
    or_cap = 1'b1; or_data = 8'h08; or_ready = 1'b1;
    if (or_valid && or_out == 8'h07) accepts++;
    tick();
    or_cap = 1'b0; or_ready = 1'b0;
    if (or_valid && or_ready && or_out == 8'h07) accepts++;
    chk("sim_valid", 32'(or_valid), 1);
    chk("sim_data", 32'(or_out), 32'h08);
    tick();
    chk("sim_07_once", 32'(accepts), 1);
    or_ready = 1'b1;
    tick();
    or_ready = 1'b0;
    tick();
    chk("sim_drained", 32'(or_valid), 0);

    // Timeout: never ack, then retry after GAP
    ack_delay = NEVER;
    p0 = pulse_q.size();
    g0 = got_q.size();
    preload(8'hEE, 1'b1);
    exp_bytes--;
    wait_pulses(p0 + 1, 10);
    p = pulse_q[p0];
    n = 0;
    while (to_rise < 0 && n < 40) begin tick(); n++; end
    chk("to_latency", 32'(to_rise - p), 32'(TO + 1));
    chk("to_outValid", 32'(outValid), 0);
    chk("to_bytesRead", bytesRead, 32'(exp_bytes));
    wait_pulses(p0 + 2, 10);
    if (pulse_q.size() > p0 + 1) chk("to_retry_gap", 32'(pulse_q[p0+1] - p), 32'(TO + 3));
    ack_delay = 1;
    exp_bytes++;
    wait_got(g0 + 1, 80);
    sb_check();
    chk("to_bytesRead_after", bytesRead, 32'(exp_bytes));
    chk("to_sticky", 32'(readTimeout), 1);

    // Spurious ack in IDLE
    repeat (4) tick();
    spur_data = 8'hAB;
    spur_ack = 1'b1;
    tick();
    spur_ack = 1'b0;
    repeat (3) tick();
    chk("spur_outValid", 32'(outValid), 0);
    chk("spur_bytesRead", bytesRead, 32'(exp_bytes));

    // Asynchronous reset while a byte is held
    outReady = 1'b0;
    ack_delay = 1;
    g0 = got_q.size();
    preload(8'h09, 1'b0);
    n = 0;
    while (!outValid && n < 20) begin tick(); n++; end
    chk("ar_held", 32'(outData), 32'h09);
    #1 reset = 1'b0;
    #1;
    chk("ar_outValid", 32'(outValid), 0);
    chk("ar_outData", 32'(outData), 0);
    chk("ar_bytesRead", bytesRead, 0);
    chk("ar_readTimeout", 32'(readTimeout), 0);
    chk("ar_readEnable", 32'(rb.readEnable), 0);
    exp_bytes = 0;
    tick();
    reset = 1'b1;
    outReady = 1'b1;
    repeat (8) tick();
    chk("ar_discarded", 32'(got_q.size() - g0), 0);
    chk("ar_timeout_after", 32'(readTimeout), 0);

    chk("sb_leftover", 32'(exp_q.size()), 0);
    chk("readEnable_single_cycle", 32'(wide_re), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
